// File: rtl/serial_byte_collector.sv
// Reassembles a serial bit stream into WIDTH-bit words behind a one-entry valid/ready holding register.
// Optional even-parity trailer bit: define SERIAL_BYTE_COLLECTOR_PARITY_CHECK_EN.
module serial_byte_collector #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     msb_first,
    input  logic                     clear,
    output logic [WIDTH-1:0]         byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overrun,
    output logic                     parity_err
);
    // state   | meaning
    // IDLE    | no partial word, bit_count == 0
    // COLLECT | partial word in progress, 0 < bit_count < WIDTH
    // PARITY  | WIDTH data bits held, waiting for the parity bit (parity build only)
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_BYTE_COLLECTOR_PARITY_CHECK_EN
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PARITY} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_COLLECT} state_t;
`endif

    state_t            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_sh, w_sh_nxt, w_shifted, w_word;
    logic [CW-1:0]     r_count, w_count_nxt;
    logic              r_dir, w_dir_nxt, w_dir;
    logic [WIDTH-1:0]  r_byte_out, w_byte_out_nxt;
    logic              r_byte_valid, w_byte_valid_nxt;
    logic              r_overrun, w_overrun_nxt;
    logic              w_complete, w_pop, w_push, w_drop;

    // Direction is taken live from msb_first only on the first bit of a word.
    assign w_dir     = (r_state == S_IDLE) ? msb_first : r_dir;
    assign w_shifted = w_dir ? {r_sh[WIDTH-2:0], bit_in} : {bit_in, r_sh[WIDTH-1:1]};

`ifdef SERIAL_BYTE_COLLECTOR_PARITY_CHECK_EN
    logic r_parity_err, w_parity_err_nxt, w_perr;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        w_complete  = 1'b0;
        w_word      = r_sh;
`ifdef SERIAL_BYTE_COLLECTOR_PARITY_CHECK_EN
        w_perr      = 1'b0;
`endif
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_sh_nxt    = '0;
            w_count_nxt = '0;
        end else if (bit_valid) begin
            case (r_state)
                S_IDLE, S_COLLECT: begin
                    w_dir_nxt = w_dir;
                    w_sh_nxt  = w_shifted;
                    if (r_count == LAST) begin
                        w_count_nxt = '0;
`ifdef SERIAL_BYTE_COLLECTOR_PARITY_CHECK_EN
                        w_state_nxt = S_PARITY;
`else
                        w_complete  = 1'b1;
                        w_word      = w_shifted;
                        w_state_nxt = S_IDLE;
`endif
                    end else begin
                        w_count_nxt = r_count + CW'(1);
                        w_state_nxt = S_COLLECT;
                    end
                end
`ifdef SERIAL_BYTE_COLLECTOR_PARITY_CHECK_EN
                S_PARITY: begin
                    w_complete  = 1'b1;
                    w_word      = r_sh;
                    w_perr      = (^r_sh) ^ bit_in;
                    w_state_nxt = S_IDLE;
                end
`endif
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A pop in the same cycle frees the holding register for the completing word.
    always_comb begin
        w_pop            = r_byte_valid && byte_ready;
        w_push           = w_complete && (!r_byte_valid || byte_ready);
        w_drop           = w_complete && r_byte_valid && !byte_ready;
        w_byte_out_nxt   = r_byte_out;
        w_byte_valid_nxt = r_byte_valid;
`ifdef SERIAL_BYTE_COLLECTOR_PARITY_CHECK_EN
        w_parity_err_nxt = r_parity_err;
`endif
        if (w_push) begin
            w_byte_out_nxt   = w_word;
            w_byte_valid_nxt = 1'b1;
`ifdef SERIAL_BYTE_COLLECTOR_PARITY_CHECK_EN
            w_parity_err_nxt = w_perr;
`endif
        end else if (w_pop) begin
            w_byte_valid_nxt = 1'b0;
        end
        w_overrun_nxt = clear ? 1'b0 : (r_overrun | w_drop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sh         <= '0;
            r_count      <= '0;
            r_dir        <= 1'b0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sh         <= w_sh_nxt;
            r_count      <= w_count_nxt;
            r_dir        <= w_dir_nxt;
            r_byte_out   <= w_byte_out_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

`ifdef SERIAL_BYTE_COLLECTOR_PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) r_parity_err <= 1'b0;
        else       r_parity_err <= w_parity_err_nxt;
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign bit_count  = r_count;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_byte_collector.sv
// Self-checking bench for serial_byte_collector: bit-queue reference model compared every cycle,
// plus directed literal checks. Parity scenarios run when SERIAL_BYTE_COLLECTOR_PARITY_CHECK_EN is defined.
module tb_serial_byte_collector;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, msb_first = 1'b1;
    logic         clear = 1'b0, byte_ready = 1'b0;
    logic [W-1:0] byte_out;
    logic         byte_valid, overrun, parity_err;
    logic [2:0]   bit_count;

    int vectors = 0;
    int miscompares = 0;

    serial_byte_collector #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .msb_first(msb_first), .clear(clear), .byte_out(byte_out),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .bit_count(bit_count),
        .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Reference model: the partial word is a queue of received bits.
    bit           m_bits[$];
    bit           m_dir = 1'b1;
    bit           m_par_pend = 1'b0;
    bit [W-1:0]   m_word = '0;
    bit [W-1:0]   m_out = '0;
    bit           m_valid = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;
    bit           m_started = 1'b0;

    function automatic bit [W-1:0] assemble(input bit dir);
        bit [W-1:0] w = '0;
        for (int i = 0; i < W; i++) begin
            if (dir) w[W-1-i] = m_bits[i];
            else     w[i]     = m_bits[i];
        end
        return w;
    endfunction

    always @(posedge clk) begin
        bit pop, comp, perr;
        bit [W-1:0] word;
        if (reset) begin
            m_bits.delete();
            m_par_pend = 0; m_out = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
            m_started = 1;
        end else begin
            pop = m_valid && byte_ready;
            comp = 0; perr = 0; word = '0;
            if (clear) begin
                m_bits.delete();
                m_par_pend = 0;
                m_ovr = 0;
            end else if (bit_valid) begin
                if (m_bits.size() == 0 && !m_par_pend) m_dir = msb_first;
`ifdef SERIAL_BYTE_COLLECTOR_PARITY_CHECK_EN
                if (m_par_pend) begin
                    comp = 1; word = m_word; perr = (^m_word) ^ bit_in; m_par_pend = 0;
                end else begin
                    m_bits.push_back(bit_in);
                    if (m_bits.size() == W) begin
                        m_word = assemble(m_dir); m_bits.delete(); m_par_pend = 1;
                    end
                end
`else
                m_bits.push_back(bit_in);
                if (m_bits.size() == W) begin
                    comp = 1; word = assemble(m_dir); m_bits.delete();
                end
`endif
            end
            if (comp) begin
                if (!m_valid || pop) begin
                    m_out = word; m_perr = perr; m_valid = 1;
                end else m_ovr = 1;
            end else if (pop) m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            vectors++;
            if (byte_valid !== m_valid || byte_out !== m_out || bit_count !== 3'(m_bits.size()) ||
                overrun !== m_ovr || parity_err !== m_perr) begin
                miscompares++;
                $display("FAIL model t=%0t: got v=%b out=%h cnt=%0d ovr=%b perr=%b, want v=%b out=%h cnt=%0d ovr=%b perr=%b",
                         $time, byte_valid, byte_out, bit_count, overrun, parity_err,
                         m_valid, m_out, m_bits.size(), m_ovr, m_perr);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit bv, input bit b, input bit rdy, input bit clr, input bit rst);
        bit_valid = bv; bit_in = b; byte_ready = rdy; clear = clr; reset = rst;
        @(posedge clk); #1;
        bit_valid = 0; byte_ready = 0; clear = 0; reset = 0;
    endtask

    task automatic send_word(input bit [W-1:0] w, input bit msb, input bit rdy_last, input int gap);
        msb_first = msb;
        for (int i = 0; i < W; i++) begin
            cyc(1, msb ? w[W-1-i] : w[i], (i == W-1) ? rdy_last : 1'b0, 0, 0);
            for (int g = 0; g < gap; g++) cyc(0, 0, 0, 0, 0);
        end
    endtask

    task automatic pop_word();
        cyc(0, 0, 1, 0, 0);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("reset_valid", int'(byte_valid), 0);
        chk("reset_out", int'(byte_out), 0);
        chk("reset_cnt", int'(bit_count), 0);

`ifndef SERIAL_BYTE_COLLECTOR_PARITY_CHECK_EN
        // MSB-first, back-to-back bits
        msb_first = 1;
        for (int i = 0; i < 7; i++) cyc(1, (i == 0 || i == 2 || i == 4), 0, 0, 0);
        chk("t1_not_yet_valid", int'(byte_valid), 0);
        chk("t1_cnt7", int'(bit_count), 7);
        cyc(1, 0, 0, 0, 0);
        chk("t1_valid", int'(byte_valid), 1);
        chk("t1_out", int'(byte_out), 8'hA8);
        chk("t1_cnt0", int'(bit_count), 0);
        chk("t1_ovr", int'(overrun), 0);

        // LSB-first, same bits, 2-cycle gaps
        pop_word();
        send_word(8'h15, 0, 0, 2);
        chk("t2_out", int'(byte_out), 8'h15);
        chk("t2_valid", int'(byte_valid), 1);

        // overrun
        pop_word();
        send_word(8'hA8, 1, 0, 0);
        send_word(8'hFF, 1, 0, 0);
        chk("t3_out_kept", int'(byte_out), 8'hA8);
        chk("t3_ovr", int'(overrun), 1);
        pop_word();
        chk("t3_popped", int'(byte_valid), 0);
        chk("t3_ovr_sticky", int'(overrun), 1);
        cyc(0, 0, 0, 1, 0);
        chk("t3_ovr_cleared", int'(overrun), 0);

        // completion together with pop
        send_word(8'h3C, 1, 0, 0);
        chk("t4_first", int'(byte_out), 8'h3C);
        send_word(8'hC3, 1, 1, 0);
        chk("t4_valid", int'(byte_valid), 1);
        chk("t4_out", int'(byte_out), 8'hC3);
        chk("t4_ovr", int'(overrun), 0);

        // partial word then reset
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("t5_reset_valid", int'(byte_valid), 0);
        send_word(8'h5A, 1, 0, 0);
        chk("t5_after_reset", int'(byte_out), 8'h5A);

        // partial word then clear with a simultaneous discarded bit
        pop_word();
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 0);
        chk("t5_clear_cnt", int'(bit_count), 0);
        send_word(8'h5A, 0, 0, 1);
        chk("t5_after_clear", int'(byte_out), 8'h5A);

        // msb_first flipped after first bit
        pop_word();
        begin
            bit [W-1:0] w;
            w = 8'h5A;
            msb_first = 1;
            cyc(1, w[7], 0, 0, 0);
            msb_first = 0;
            for (int i = 6; i >= 0; i--) cyc(1, w[i], 0, 0, 0);
        end
        chk("t5_dir_latched", int'(byte_out), 8'h5A);
        chk("t5_perr_tied", int'(parity_err), 0);
`else
        // A8 + parity 1 (even parity correct)
        send_word(8'hA8, 1, 0, 0);
        chk("p1_no_valid_after_8", int'(byte_valid), 0);
        chk("p1_cnt_hold", int'(bit_count), 0);
        cyc(0, 0, 0, 0, 0);
        chk("p1_still_waiting", int'(byte_valid), 0);
        cyc(1, 1, 0, 0, 0);
        chk("p1_valid", int'(byte_valid), 1);
        chk("p1_out", int'(byte_out), 8'hA8);
        chk("p1_perr", int'(parity_err), 0);
        pop_word();
        send_word(8'hA8, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("p2_out", int'(byte_out), 8'hA8);
        chk("p2_perr", int'(parity_err), 1);
        // overrun on parity completion, clear while in PARITY
        send_word(8'h0F, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("p3_ovr", int'(overrun), 1);
        chk("p3_kept", int'(byte_out), 8'hA8);
        pop_word();
        send_word(8'h33, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0);
        chk("p4_clear_abort", int'(byte_valid), 0);
        chk("p4_cnt", int'(bit_count), 1);
        cyc(0, 0, 0, 1, 0);
        send_word(8'hC3, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("p4_out", int'(byte_out), 8'hC3);
        chk("p4_perr", int'(parity_err), 0);
`endif
        cyc(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
